// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: request/result bundle for the sequential binary-to-BCD
// converter.
//   start    - conversion request (master -> slave)
//   entrada  - WIDTH-bit binary operand, captured on an accepted start
//   digitos  - DIGITS packed BCD digits, units in [3:0]
//   busy     - conversion in progress
//   done     - one-cycle pulse, digitos/negativo hold a fresh result
//   negativo - sign of the last result (signed build only, else 0)
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      entrada;
  logic [4*DIGITS-1:0]   digitos;
  logic                  busy;
  logic                  done;
  logic                  negativo;

  modport master (output start, entrada, input digitos, busy, done, negativo);
  modport slave  (input start, entrada, output digitos, busy, done, negativo);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble (shift-add-3) converter, one input
// bit per clock. Feeds the 7-segment BCD decoders.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; aborts any conversion in flight
//   bus   - bin2bcd_seq_if slave: start/entrada in, digitos/busy/done/
//           negativo out
// Timing: start accepted at edge N -> busy seen high at edges N+1..N+WIDTH,
// done (and new digitos) seen at edge N+WIDTH+1. A start presented during
// the DONE cycle is accepted, giving one result every WIDTH+1 cycles.
// Build option: define BIN2BCD_SIGNED_EN to treat entrada as two's
// complement (converts |entrada|, sign reported on negativo). Without it
// entrada is unsigned and negativo stays 0.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic           clk,
  input  logic           reset,
  bin2bcd_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       sh_q, sh_d;
  logic [DIGITS-1:0][3:0] bcd_q, bcd_adj, bcd_d;
  logic [CW-1:0]          cnt_q;
  logic [BW-1:0]          dig_q;
  logic                   sign_q, neg_q;
  logic                   accept, last;
  logic [WIDTH-1:0]       mag;
  logic                   sgn;
  logic [BW+WIDTH-1:0]    cat;

  // Operand conditioning at load time.
`ifdef BIN2BCD_SIGNED_EN
  // Most negative value negates to itself, which read as unsigned is the
  // correct magnitude (e.g. 8'h80 -> 128).
  assign sgn = bus.entrada[WIDTH-1];
  assign mag = sgn ? (~bus.entrada + 1'b1) : bus.entrada;
`else
  assign sgn = 1'b0;
  assign mag = bus.entrada;
`endif

  assign accept = bus.start && (state_q == IDLE || state_q == DONE);
  assign last   = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));

  // Per-digit add-3 correction ahead of the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
  end

  always_comb begin
    cat   = {bcd_adj, sh_q};
    cat   = cat << 1;
    bcd_d = cat[BW+WIDTH-1:WIDTH];
    sh_d  = cat[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath. Results are only published on the final shift, so digitos
  // and negativo hold steady through a following conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
      dig_q  <= '0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      sh_q   <= mag;
      bcd_q  <= '0;
      cnt_q  <= '0;
      sign_q <= sgn;
    end else if (state_q == SHIFT) begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_q + 1'b1;
      if (last) begin
        dig_q <= bcd_d;
        neg_q <= sign_q;
      end
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = (state_q == DONE);
  assign bus.digitos  = dig_q;
  assign bus.negativo = neg_q;
endmodule
